// File: rtl/r88_pkg.sv
//------------------------------------------------------------------------------
// r88_pkg
//   Shared interrupt kind codes, vector addresses, controller states.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package r88_pkg;

  localparam logic [1:0] c_kindReset = 2'd0;
  localparam logic [1:0] c_kindNmi   = 2'd1;
  localparam logic [1:0] c_kindIrq   = 2'd2;
  localparam logic [1:0] c_kindBrk   = 2'd3;

  localparam logic [15:0] c_vecReset = 16'hFFFC;
  localparam logic [15:0] c_vecNmi   = 16'hFFFA;
  localparam logic [15:0] c_vecIrq   = 16'hFFFE;
  localparam logic [15:0] c_vecBrk   = 16'hFFFE;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    IDLE = 2'd1,
    REQ  = 2'd2
  } stateT;

  function automatic logic [15:0] vectorFor(input logic [1:0] kind);
    case (kind)
      c_kindNmi: vectorFor = c_vecNmi;
      c_kindIrq: vectorFor = c_vecIrq;
      c_kindBrk: vectorFor = c_vecBrk;
      default:   vectorFor = c_vecReset;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/r88_sync.sv
//------------------------------------------------------------------------------
// r88_sync
//   Multi-flop synchronizer for one asynchronous input, async active-low reset.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module r88_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync
);

  logic [SYNC_STAGES-1:0] r_stages;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stages <= '0;
    end else begin
      r_stages <= {r_stages[SYNC_STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_stages[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/r88_intctl.sv
//------------------------------------------------------------------------------
// r88_intctl
//   Reset/NMI/IRQ/BRK sequencer for the R88 decoder. Macro R88_BRK_TRAP_EN
//   adds the software BRK source.   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module r88_intctl
  import r88_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int RESET_HOLD  = 4
) (
  input  logic        sysClock,
  input  logic        resetReqN,
  input  logic        nmiReq,
  input  logic        irq,
  input  logic        irqEn,
  input  logic        breakFlag,
  input  logic        instrBoundary,
  input  logic        intAck,
  output logic        coreReset,
  output logic        intReq,
  output logic [1:0]  intKind,
  output logic [15:0] vectorAddr,
  output logic        nmiPending
);

  localparam int                c_cntW     = $clog2(RESET_HOLD + 1);
  localparam logic [c_cntW-1:0] c_holdLoad = c_cntW'(RESET_HOLD);
  localparam logic [c_cntW-1:0] c_cntOne   = c_cntW'(1);

  logic              w_nmiSync;
  logic              w_irqSync;
  logic              w_nmiEdge;
  logic              w_irqActive;
  logic              w_ackNmi;
  logic              r_nmiPrev;
  logic              r_nmiPending;
  stateT             r_state;
  stateT             w_stateNext;
  logic [c_cntW-1:0] r_cnt;
  logic [c_cntW-1:0] w_cntNext;
  logic [1:0]        r_kind;
  logic [1:0]        w_kindNext;

  r88_sync #(.SYNC_STAGES(SYNC_STAGES)) u_nmiSync (
    .clk    (sysClock),
    .rst_n  (resetReqN),
    .i_async(nmiReq),
    .o_sync (w_nmiSync)
  );

  r88_sync #(.SYNC_STAGES(SYNC_STAGES)) u_irqSync (
    .clk    (sysClock),
    .rst_n  (resetReqN),
    .i_async(irq),
    .o_sync (w_irqSync)
  );

`ifdef R88_BRK_TRAP_EN
  logic w_brkActive;
  assign w_brkActive = breakFlag;
`else
  logic w_unusedBreak;
  assign w_unusedBreak = breakFlag;
`endif

  assign w_nmiEdge   = w_nmiSync & ~r_nmiPrev;
  assign w_irqActive = w_irqSync & irqEn;
  assign w_ackNmi    = (r_state == REQ) & intAck & (r_kind == c_kindNmi);

  // A fresh edge wins over the clearing ack so a back-to-back NMI is kept.
  always_ff @(posedge sysClock or negedge resetReqN) begin
    if (!resetReqN) begin
      r_nmiPrev    <= 1'b0;
      r_nmiPending <= 1'b0;
    end else begin
      r_nmiPrev <= w_nmiSync;
      if (w_nmiEdge) begin
        r_nmiPending <= 1'b1;
      end else if (w_ackNmi) begin
        r_nmiPending <= 1'b0;
      end
    end
  end

  always_ff @(posedge sysClock or negedge resetReqN) begin
    if (!resetReqN) begin
      r_state <= HOLD;
      r_cnt   <= c_holdLoad;
      r_kind  <= c_kindReset;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
      r_kind  <= w_kindNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    w_kindNext  = r_kind;
    case (r_state)
      HOLD: begin
        if (r_cnt <= c_cntOne) begin
          w_stateNext = REQ;
          w_cntNext   = '0;
          w_kindNext  = c_kindReset;
        end else begin
          w_cntNext = r_cnt - c_cntOne;
        end
      end
      IDLE: begin
        if (instrBoundary) begin
          if (r_nmiPending) begin
            w_stateNext = REQ;
            w_kindNext  = c_kindNmi;
          end else if (w_irqActive) begin
            w_stateNext = REQ;
            w_kindNext  = c_kindIrq;
          end
`ifdef R88_BRK_TRAP_EN
          else if (w_brkActive) begin
            w_stateNext = REQ;
            w_kindNext  = c_kindBrk;
          end
`endif
        end
      end
      REQ: begin
        if (intAck) begin
          w_stateNext = IDLE;
        end
      end
      default: begin
        w_stateNext = HOLD;
        w_cntNext   = c_holdLoad;
        w_kindNext  = c_kindReset;
      end
    endcase
  end

  assign coreReset  = (r_state == HOLD);
  assign intReq     = (r_state == REQ);
  assign intKind    = r_kind;
  assign vectorAddr = vectorFor(r_kind);
  assign nmiPending = r_nmiPending;

endmodule

`default_nettype wire

// File: doc/r88_intctl.md
R88_INTCTL -- requirements
Module: r88_intctl

Interface
REQ-001 Parameter: SYNC_STAGES, default 2, synchronizer depth for nmiReq and irq (minimum 2).
REQ-002 Parameter: RESET_HOLD, default 4, number of cycles coreReset stays high after reset release (minimum 1).
REQ-003 sysClock  in  1  sole clock; all state on rising edge.
REQ-004 resetReqN  in  1  asynchronous, active-low reset.
REQ-005 nmiReq  in  1  asynchronous NMI request; rising-edge sensitive.
REQ-006 irq  in  1  asynchronous maskable interrupt; level sensitive.
REQ-007 irqEn  in  1  IRQ enable flag from the register block.
REQ-008 breakFlag  in  1  software break flag from the register block.
REQ-009 instrBoundary  in  1  decoder pulse, high for one cycle at the end of each instruction.
REQ-010 intAck  in  1  decoder acknowledge: vector fetch has been taken.
REQ-011 coreReset  out  1  holds the decoder and registers in reset.
REQ-012 intReq  out  1  service request to the decoder.
REQ-013 intKind  out  2  source being serviced: 0 RESET, 1 NMI, 2 IRQ, 3 BRK.
REQ-014 vectorAddr  out  16  vector address for intKind.
REQ-015 nmiPending  out  1  NMI edge latched and not yet serviced.

Function
REQ-016 nmiReq and irq SHALL each pass through SYNC_STAGES flops before use; the other inputs are already synchronous.
REQ-017 A 0->1 transition of synchronized nmiReq SHALL set nmiPending on the next edge. It SHALL clear only on intAck while intKind=1 in REQ. A new edge coinciding with that ack SHALL leave it set.
REQ-018 The IRQ source SHALL be active while synchronized irq=1 and irqEn=1; it SHALL NOT be latched.
REQ-019 The BRK source SHALL be active while breakFlag=1 (see REQ-031).
REQ-020 States: HOLD, IDLE, REQ.
REQ-021 HOLD: coreReset=1 and a down-counter loaded with RESET_HOLD decrements each cycle. At 0 the block SHALL enter REQ with intKind=0 and coreReset=0 on the same edge, without waiting for instrBoundary.
REQ-022 IDLE: when instrBoundary=1 and any source is active, the block SHALL latch the highest-priority source and enter REQ on the next edge. Priority: NMI > IRQ > BRK.
REQ-023 REQ: intReq=1. intKind and vectorAddr SHALL stay stable until intAck=1, then the block returns to IDLE on the next edge.
REQ-024 Latency: instrBoundary sampled at edge N SHALL give intReq=1 after edge N.
REQ-025 Vectors: RESET 0xFFFC, NMI 0xFFFA, IRQ 0xFFFE, BRK 0xFFFE.
REQ-026 A higher-priority source arriving during REQ SHALL NOT preempt the latched request; it is serviced at a later boundary.
REQ-027 IRQ deasserting or irqEn clearing during REQ SHALL NOT withdraw the request.
REQ-028 After intAck, intReq SHALL be low for at least one cycle.
REQ-029 intAck outside REQ, and instrBoundary outside IDLE, SHALL be ignored.

Reset
REQ-030 While resetReqN=0: state HOLD, counter=RESET_HOLD, synchronizers=0, coreReset=1, intReq=0, intKind=0, vectorAddr=0xFFFC, nmiPending=0. Asserting resetReqN mid-REQ SHALL abort that request immediately.

Configuration
REQ-031 Macro R88_BRK_TRAP_EN. When defined, BRK is a source per REQ-019 and REQ-022. When undefined, breakFlag is ignored, intKind never equals 3, and the BRK logic is absent.

Structure
REQ-032 Shared package r88_pkg SHALL hold the intKind encodings, the four vector constants and the state enumeration.
REQ-033 Sub-module r88_sync: a SYNC_STAGES-deep synchronizer with asynchronous active-low reset, instantiated once per asynchronous input.

Verification
REQ-034 Release resetReqN with RESET_HOLD=4 -> coreReset high for exactly 4 edges, then intReq=1, intKind=0, vectorAddr=0xFFFC; intAck -> IDLE.
REQ-035 Pulse nmiReq, then instrBoundary at least 3 cycles later -> nmiPending=1, intReq next cycle with intKind=1 and vectorAddr=0xFFFA; intAck clears nmiPending.
REQ-036 irq=1 with irqEn=0, then instrBoundary -> no request. Set irqEn=1, then instrBoundary -> intKind=2, vectorAddr=0xFFFE.
REQ-037 irq and nmiPending both active at a boundary -> NMI serviced first; IRQ serviced at the next boundary after the ack.
REQ-038 NMI edge during an IRQ in REQ -> intKind stays 2 until ack; NMI serviced at the following boundary.
REQ-039 With R88_BRK_TRAP_EN: breakFlag=1 at a boundary -> intKind=3, vectorAddr=0xFFFE. Without the macro -> no request.
